aes_inv_round_state: RTL and testbench

//  Decryption-side state register and round sequencer of the AES-128 core.

---
 rtl/aes_pkg.sv | 38 +++
 rtl/aes_inv_mixcol.sv | 21 ++
 rtl/aes_inv_round_state.sv | 99 +++++++++
 tb/tb_aes_inv_round_state.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, GF(2^8) helpers and the inverse round sequencer FSM encoding.
package aes_pkg;

  localparam int AES_NR = 10;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  word_t;

  typedef enum logic [1:0] {
    FSM_IDLE,
    FSM_INIT,
    FSM_ROUND,
    FSM_FINAL
  } aes_fsm_e;

  // Byte at row r, column c; column-major with s00 in the top byte.
  function automatic logic [7:0] get_byte(input state_t s, input int unsigned r,
                                          input int unsigned c);
    return s[127 - 8*(4*c + r) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] prod;
    logic [7:0] acc;
    prod = 8'h00;
    acc  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) prod = prod ^ acc;
      acc = xtime(acc);
    end
    return prod;
  endfunction

endpackage

// File: rtl/aes_inv_mixcol.sv
// Combinational InvMixColumns on one 32-bit column (row 0 in bits 31:24).
// Only compiled when AES_INV_MIXCOL_INT_EN is defined.
`ifdef AES_INV_MIXCOL_INT_EN
module aes_inv_mixcol
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  logic [7:0] b0, b1, b2, b3;

  assign {b0, b1, b2, b3} = col_i;

  assign col_o[31:24] = gf_mul(b0, 8'h0e) ^ gf_mul(b1, 8'h0b) ^ gf_mul(b2, 8'h0d) ^ gf_mul(b3, 8'h09);
  assign col_o[23:16] = gf_mul(b0, 8'h09) ^ gf_mul(b1, 8'h0e) ^ gf_mul(b2, 8'h0b) ^ gf_mul(b3, 8'h0d);
  assign col_o[15:8]  = gf_mul(b0, 8'h0d) ^ gf_mul(b1, 8'h09) ^ gf_mul(b2, 8'h0e) ^ gf_mul(b3, 8'h0b);
  assign col_o[7:0]   = gf_mul(b0, 8'h0b) ^ gf_mul(b1, 8'h0d) ^ gf_mul(b2, 8'h09) ^ gf_mul(b3, 8'h0e);

endmodule
`endif

// File: rtl/aes_inv_round_state.sv
// AES-128 decrypt state register and round sequencer (rk10 down to rk0).
// Define AES_INV_MIXCOL_INT_EN to apply InvMixColumns internally in the middle rounds.
module aes_inv_round_state
  import aes_pkg::*;
#(
  parameter int NR  = AES_NR,
  parameter int KRW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ld,
  input  logic [127:0]   text_in,
  input  logic [31:0]    w0,
  input  logic [31:0]    w1,
  input  logic [31:0]    w2,
  input  logic [31:0]    w3,
  input  logic [127:0]   sa_next_i,
  output logic [KRW-1:0] key_rnd,
  output logic [127:0]   state_o,
  output logic [127:0]   text_out,
  output logic           busy,
  output logic           done
);

  aes_fsm_e       fsm_q;
  logic [KRW-1:0] keyRnd_q;
  state_t         state_q;
  state_t         textOut_q;
  state_t         textIn_q;
  logic           busy_q;
  logic           done_q;

  state_t roundKey;
  state_t addKey;
  state_t roundState_d;

  assign roundKey = {w0, w1, w2, w3};
  assign addKey   = sa_next_i ^ roundKey;

`ifdef AES_INV_MIXCOL_INT_EN
  for (genvar c = 0; c < 4; c++) begin : g_mixcol
    aes_inv_mixcol u_mixcol (
      .col_i (addKey[127-32*c -: 32]),
      .col_o (roundState_d[127-32*c -: 32])
    );
  end
`else
  // Without the internal mixer the outer datapath folds InvMixColumns into sa_next_i.
  assign roundState_d = addKey;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q     <= FSM_IDLE;
      keyRnd_q  <= KRW'(NR);
      state_q   <= '0;
      textOut_q <= '0;
      textIn_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (fsm_q)
        FSM_IDLE: begin
          if (ld) begin
            textIn_q <= text_in;
            keyRnd_q <= KRW'(NR);
            busy_q   <= 1'b1;
            fsm_q    <= FSM_INIT;
          end
        end
        FSM_INIT: begin
          state_q  <= textIn_q ^ roundKey;
          keyRnd_q <= KRW'(NR - 1);
          fsm_q    <= FSM_ROUND;
        end
        FSM_ROUND: begin
          state_q  <= roundState_d;
          keyRnd_q <= keyRnd_q - KRW'(1);
          if (keyRnd_q == KRW'(1)) fsm_q <= FSM_FINAL;
        end
        FSM_FINAL: begin
          textOut_q <= addKey;
          done_q    <= 1'b1;
          keyRnd_q  <= KRW'(NR);
          busy_q    <= 1'b0;
          fsm_q     <= FSM_IDLE;
        end
      endcase
    end
  end

  assign key_rnd  = keyRnd_q;
  assign state_o  = state_q;
  assign text_out = textOut_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_aes_inv_round_state.sv
// Bench for aes_inv_round_state: models the key schedule and InvShiftRows/InvSubBytes
// path around the core and checks known AES-128 ciphertext/plaintext pairs.
module tb_aes_inv_round_state;

`ifdef AES_INV_MIXCOL_INT_EN
  localparam bit INT_MIX = 1'b1;
`else
  localparam bit INT_MIX = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         ld;
  logic [127:0] textIn;
  logic [31:0]  w0, w1, w2, w3;
  logic [127:0] saNext;
  logic [3:0]   keyRnd;
  logic [127:0] stateO;
  logic [127:0] textOut;
  logic         busy;
  logic         done;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [7:0]  sboxTab[256];
  logic [7:0]  isboxTab[256];
  logic [31:0] wTab[44];
  logic        tablesReady = 1'b0;

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  vec_t vecs[4];

  always #5 clk = ~clk;

  aes_inv_round_state dut (
    .clk       (clk),
    .rst       (rst),
    .ld        (ld),
    .text_in   (textIn),
    .w0        (w0),
    .w1        (w1),
    .w2        (w2),
    .w3        (w3),
    .sa_next_i (saNext),
    .key_rnd   (keyRnd),
    .state_o   (stateO),
    .text_out  (textOut),
    .busy      (busy),
    .done      (done)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    while (bb != 8'h00) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [127:0] imcState(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] b0, b1, b2, b3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      b0 = s[127-32*c -: 8];
      b1 = s[119-32*c -: 8];
      b2 = s[111-32*c -: 8];
      b3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(8'h0e, b0) ^ gmul(8'h0b, b1) ^ gmul(8'h0d, b2) ^ gmul(8'h09, b3);
      o[119-32*c -: 8] = gmul(8'h09, b0) ^ gmul(8'h0e, b1) ^ gmul(8'h0b, b2) ^ gmul(8'h0d, b3);
      o[111-32*c -: 8] = gmul(8'h0d, b0) ^ gmul(8'h09, b1) ^ gmul(8'h0e, b2) ^ gmul(8'h0b, b3);
      o[103-32*c -: 8] = gmul(8'h0b, b0) ^ gmul(8'h0d, b1) ^ gmul(8'h09, b2) ^ gmul(8'h0e, b3);
    end
    return o;
  endfunction

  // InvShiftRows (row r rotated right by r) followed by InvSubBytes.
  function automatic logic [127:0] invShiftSub(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
        o[127 - 8*(4*c + r) -: 8] = isboxTab[src];
      end
    end
    return o;
  endfunction

  // External datapath: without the internal mixer, states left by a middle round
  // (key_rnd 8..0) get InvMixColumns before the shift/substitute step.
  function automatic logic [127:0] modelSaNext(input logic [127:0] s, input logic [3:0] kr);
    logic [127:0] t;
    t = s;
    if (!INT_MIX && kr <= 4'd8) t = imcState(s);
    return invShiftSub(t);
  endfunction

  assign saNext = tablesReady ? modelSaNext(stateO, keyRnd) : 128'h0;
  assign w0 = (keyRnd <= 4'd10) ? wTab[4*keyRnd]     : 32'h0;
  assign w1 = (keyRnd <= 4'd10) ? wTab[4*keyRnd + 1] : 32'h0;
  assign w2 = (keyRnd <= 4'd10) ? wTab[4*keyRnd + 2] : 32'h0;
  assign w3 = (keyRnd <= 4'd10) ? wTab[4*keyRnd + 3] : 32'h0;

  task automatic buildTables();
    logic [7:0] inv;
    logic [7:0] x;
    for (int i = 0; i < 256; i++) begin
      x   = 8'(i);
      inv = 8'h00;
      for (int j = 1; j < 256; j++) begin
        if (gmul(x, 8'(j)) == 8'h01) inv = 8'(j);
      end
      sboxTab[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    for (int i = 0; i < 256; i++) isboxTab[sboxTab[i]] = 8'(i);
  endtask

  task automatic setKey(input logic [127:0] key);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) wTab[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = wTab[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sboxTab[t[31:24]], sboxTab[t[23:16]], sboxTab[t[15:8]], sboxTab[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      wTab[i] = wTab[i-4] ^ t;
    end
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Pulse ld for one cycle, then wait (bounded) for done; cycles counts edges from
  // the one that samples ld, so a correct run returns 12.
  task automatic applyStimulus(input logic [127:0] ct, output int cycles, output logic busyAfterLd);
    @(negedge clk);
    textIn = ct;
    ld     = 1'b1;
    @(negedge clk);
    ld          = 1'b0;
    busyAfterLd = busy;
    cycles      = 1;
    while (done !== 1'b1 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
  endtask

`ifdef AES_INV_MIXCOL_INT_EN
  logic [31:0] mcIn;
  logic [31:0] mcOut;

  aes_inv_mixcol u_unit (
    .col_i (mcIn),
    .col_o (mcOut)
  );
`endif

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int   cycles;
    logic busyAfterLd;
    int   doneCount;
    int   doneCycle;
    int   expKr;

    rst    = 1'b1;
    ld     = 1'b0;
    textIn = '0;
    buildTables();
    tablesReady = 1'b1;

    vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                128'h00112233445566778899aabbccddeeff};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
                128'h3243f6a8885a308d313198a2e0370734};
    vecs[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3ad77bb40d7a3660a89ecaf32466ef97,
                128'h6bc1bee22e409f96e93d7e117393172a};
    vecs[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hf5d3d58503b9699de785895a96fdbaaf,
                128'hae2d8a571e03ac9c9eb76fac45af8e51};

    setKey(vecs[0].key);
    repeat (3) @(negedge clk);
    checkOutput("reset state_o", stateO, 128'h0);
    checkOutput("reset text_out", textOut, 128'h0);
    checkOutput("reset busy", 128'(busy), 128'h0);
    checkOutput("reset done", 128'(done), 128'h0);
    checkOutput("reset key_rnd", 128'(keyRnd), 128'd10);
    rst = 1'b0;

`ifdef AES_INV_MIXCOL_INT_EN
    begin
      logic [31:0] mcVecIn[5]  = '{32'h8e4da1bc, 32'h9fdc589d, 32'h4d7ebdf8, 32'h01010101, 32'h00000000};
      logic [31:0] mcVecOut[5] = '{32'hdb135345, 32'hf20a225c, 32'h2d26314c, 32'h01010101, 32'h00000000};
      for (int i = 0; i < 5; i++) begin
        mcIn = mcVecIn[i];
        #1;
        checkOutput($sformatf("inv_mixcol col %0d", i), 128'(mcOut), 128'(mcVecOut[i]));
      end
    end
`endif

    for (int i = 0; i < 4; i++) begin
      setKey(vecs[i].key);
      applyStimulus(vecs[i].ct, cycles, busyAfterLd);
      checkOutput($sformatf("vec%0d busy after ld", i), 128'(busyAfterLd), 128'h1);
      checkOutput($sformatf("vec%0d done latency", i), 128'(cycles), 128'd12);
      checkOutput($sformatf("vec%0d text_out", i), textOut, vecs[i].pt);
      checkOutput($sformatf("vec%0d busy at done", i), 128'(busy), 128'h0);
      checkOutput($sformatf("vec%0d key_rnd at done", i), 128'(keyRnd), 128'd10);
      @(negedge clk);
      checkOutput($sformatf("vec%0d done single pulse", i), 128'(done), 128'h0);
      checkOutput($sformatf("vec%0d text_out held", i), textOut, vecs[i].pt);
    end

    // ld pulses sampled at edges 3 and 7 of a run must be ignored.
    setKey(vecs[0].key);
    @(negedge clk);
    textIn = vecs[0].ct;
    ld     = 1'b1;
    @(negedge clk);
    ld        = 1'b0;
    doneCount = 0;
    doneCycle = 0;
    for (int k = 1; k <= 25; k++) begin
      if (done === 1'b1) begin
        doneCount++;
        if (doneCycle == 0) doneCycle = k;
      end
      ld     = (k == 2 || k == 6);
      textIn = ld ? 128'hdeadbeef_cafef00d_01234567_89abcdef : vecs[0].ct;
      @(negedge clk);
    end
    ld = 1'b0;
    checkOutput("ld-while-busy done count", 128'(doneCount), 128'd1);
    checkOutput("ld-while-busy done cycle", 128'(doneCycle), 128'd12);
    checkOutput("ld-while-busy text_out", textOut, vecs[0].pt);

    // Reset sampled at edge 6 of a run aborts it.
    @(negedge clk);
    textIn = vecs[0].ct;
    ld     = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort busy", 128'(busy), 128'h0);
    checkOutput("abort done", 128'(done), 128'h0);
    checkOutput("abort state_o", stateO, 128'h0);
    checkOutput("abort key_rnd", 128'(keyRnd), 128'd10);
    checkOutput("abort text_out", textOut, 128'h0);
    rst       = 1'b0;
    doneCount = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done === 1'b1) doneCount++;
    end
    checkOutput("abort no done", 128'(doneCount), 128'h0);
    applyStimulus(vecs[0].ct, cycles, busyAfterLd);
    checkOutput("after abort latency", 128'(cycles), 128'd12);
    checkOutput("after abort text_out", textOut, vecs[0].pt);

    // Back-to-back: second ld in the done cycle of the first run.
    setKey(vecs[2].key);
    applyStimulus(vecs[2].ct, cycles, busyAfterLd);
    checkOutput("b2b first latency", 128'(cycles), 128'd12);
    checkOutput("b2b first text_out", textOut, vecs[2].pt);
    textIn = vecs[3].ct;
    ld     = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    checkOutput("b2b second accepted", 128'(busy), 128'h1);
    for (int k = 1; k <= 12; k++) begin
      expKr = (k == 1) ? 10 : ((k <= 11) ? 11 - k : 10);
      checkOutput($sformatf("b2b key_rnd k=%0d", k), 128'(keyRnd), 128'(expKr));
      if (k == 11) checkOutput("b2b text_out before done", textOut, vecs[2].pt);
      if (k < 12) begin
        checkOutput($sformatf("b2b done low k=%0d", k), 128'(done), 128'h0);
        @(negedge clk);
      end
    end
    checkOutput("b2b second done", 128'(done), 128'h1);
    checkOutput("b2b second text_out", textOut, vecs[3].pt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
